// File: rtl/hs32_fetch_if.sv
// Fetch-stage bus bundle: memory read port on one side, decode handshake on the other.
`timescale 1ns/1ps
interface hs32_fetch_if;
    logic [31:0] addr;
    logic        rtrq;
    logic        ready;
    logic        dtr;
    logic [31:0] dread;
    logic [31:0] instd;
    logic [31:0] pc_d;
    logic        ackd;
    logic        reqd;
    logic        flush;
    logic [31:0] newpc;

    modport master (
        output addr, rtrq, instd, pc_d, ackd,
        input  ready, dtr, dread, reqd, flush, newpc
    );

    modport slave (
        input  addr, rtrq, instd, pc_d, ackd,
        output ready, dtr, dread, reqd, flush, newpc
    );
endinterface

// File: rtl/hs32_fetch.sv
// HS32 instruction fetch: one outstanding memory read at a time, results
// buffered in a small prefetch FIFO and offered to decode with a valid/ready pair.
`timescale 1ns/1ps
module hs32_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic         clk,
    input  logic         reset,
    hs32_fetch_if.master bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] pc;
    } entry_t;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t        state;
    logic [31:0]   pc;
    logic [31:0]   req_pc;
    entry_t        fifo [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic          push_c;
    logic          pop_c;
    logic          can_issue_c;
    logic [PW-1:0] rd_ptr_nxt_c;
    logic [CW-1:0] count_nxt_c;
    entry_t        head_nxt_c;

    // FIFO bookkeeping; the head register is loaded with whatever will sit at the head next.
    always_comb begin
        push_c       = (state == WAIT) && bus.dtr && !bus.flush;
        pop_c        = bus.ackd && bus.reqd && !bus.flush;
        rd_ptr_nxt_c = pop_c ? rd_ptr + PW'(1) : rd_ptr;
        count_nxt_c  = count + CW'(push_c) - CW'(pop_c);
        can_issue_c  = count < CW'(DEPTH);
        if (push_c && ((count - CW'(pop_c)) == '0)) begin
            head_nxt_c.insn = bus.dread;
            head_nxt_c.pc   = req_pc;
        end else begin
            head_nxt_c = fifo[rd_ptr_nxt_c];
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo[wr_ptr] <= '{insn: bus.dread, pc: req_pc};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            req_pc    <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            bus.rtrq  <= 1'b0;
            bus.addr  <= '0;
            bus.ackd  <= 1'b0;
            bus.instd <= '0;
            bus.pc_d  <= '0;
        end else if (bus.flush) begin
            // An accepted read still owes us a dtr, so it must be drained in DROP.
            pc       <= bus.newpc;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            bus.ackd <= 1'b0;
            bus.rtrq <= 1'b0;
            case (state)
                IDLE:       state <= IDLE;
                REQ:        state <= bus.ready ? DROP : IDLE;
                WAIT, DROP: state <= bus.dtr ? IDLE : DROP;
                default:    state <= IDLE;
            endcase
        end else begin
            rd_ptr   <= rd_ptr_nxt_c;
            count    <= count_nxt_c;
            bus.ackd <= (count_nxt_c != '0);
            if (push_c) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (count_nxt_c != '0) begin
                bus.instd <= head_nxt_c.insn;
                bus.pc_d  <= head_nxt_c.pc;
            end
            case (state)
                IDLE: begin
                    if (can_issue_c) begin
                        state    <= REQ;
                        bus.rtrq <= 1'b1;
                        bus.addr <= pc;
                        req_pc   <= pc;
                    end
                end
                REQ: begin
                    if (bus.ready) begin
                        pc       <= pc + 32'd4;
                        bus.rtrq <= 1'b0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.dtr) begin
                        state <= IDLE;
                    end
                end
                DROP: begin
                    if (bus.dtr) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hs32_fetch.sv
// Bench for hs32_fetch: memory responder, queue-based model of the delivered
// instruction stream checked every cycle, plus directed timing scenarios.
`timescale 1ns/1ps
module tb_hs32_fetch;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] pc;
    } ent_t;

    logic clk = 1'b0;
    logic reset;

    hs32_fetch_if bus ();
    hs32_fetch_if bus2 ();

    hs32_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    // Second copy starting near the top of the address space, sharing all inputs.
    hs32_fetch #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(DEPTH)) dut_wrap (
        .clk(clk), .reset(reset), .bus(bus2)
    );

    assign bus2.ready = bus.ready;
    assign bus2.dtr   = bus.dtr;
    assign bus2.dread = bus.dread;
    assign bus2.reqd  = bus.reqd;
    assign bus2.flush = bus.flush;
    assign bus2.newpc = bus.newpc;

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // model of the instruction stream decode should see
    ent_t        q[$];
    logic [31:0] exp_pc;
    logic [31:0] acc_pc;
    bit          outst;
    bit          drop;
    int          n_push;

    // values sampled just before each active edge
    logic        p_reset, p_flush, p_rtrq, p_ready, p_dtr, p_ackd, p_reqd;
    logic [31:0] p_newpc, p_addr, p_dread;

    // memory responder
    bit          auto_mem;
    int          lat_cnt;
    int          maxlat;
    logic [31:0] lat_addr;

    function automatic logic [31:0] memval(input logic [31:0] a);
        if (a == 32'h0) return 32'h1234_5678;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        bit occ_ok;
        if (!p_reset) begin
            q.delete();
            exp_pc = RESET_PC;
            outst  = 1'b0;
            drop   = 1'b0;
        end else if (p_flush) begin
            q.delete();
            exp_pc = p_newpc;
            if (p_rtrq && p_ready) begin
                outst = 1'b1;
                drop  = 1'b1;
            end else if (outst && p_dtr) begin
                outst = 1'b0;
            end else if (outst) begin
                drop = 1'b1;
            end
        end else begin
            if (p_ackd && p_reqd && q.size() != 0) q.delete(0);
            if (p_rtrq && p_ready) begin
                acc_pc = exp_pc;
                exp_pc = exp_pc + 32'd4;
                outst  = 1'b1;
                drop   = 1'b0;
            end else if (outst && p_dtr) begin
                if (!drop) begin
                    q.push_back('{insn: p_dread, pc: acc_pc});
                    n_push++;
                end
                outst = 1'b0;
            end
        end

        chk1("ackd", bus.ackd, q.size() != 0);
        if (q.size() != 0) begin
            chk("instd", bus.instd, q[0].insn);
            chk("pc_d", bus.pc_d, q[0].pc);
        end
        occ_ok = (q.size() + ((bus.rtrq || outst) ? 1 : 0)) <= DEPTH;
        chk1("occupancy", occ_ok, 1'b1);
        if (bus.rtrq) begin
            chk("addr", bus.addr, exp_pc);
            chk1("single_outstanding", outst, 1'b0);
        end
        if (!p_reset || p_flush) chk1("rtrq_off", bus.rtrq, 1'b0);
        else if (p_rtrq && !p_ready) chk1("rtrq_hold", bus.rtrq, 1'b1);
        if (!p_reset) begin
            chk("reset_addr", bus.addr, 32'h0);
            chk("reset_instd", bus.instd, 32'h0);
            chk("reset_pc_d", bus.pc_d, 32'h0);
        end
    endtask

    // One clock: sample, advance model, check, then drive memory at the falling edge.
    task automatic cycle();
        @(posedge clk);
        p_reset = reset;     p_flush = bus.flush; p_newpc = bus.newpc;
        p_rtrq  = bus.rtrq;  p_ready = bus.ready; p_addr  = bus.addr;
        p_dtr   = bus.dtr;   p_dread = bus.dread;
        p_ackd  = bus.ackd;  p_reqd  = bus.reqd;
        #1;
        model_check();
        if (!p_reset) begin
            lat_cnt = 0;
        end else if (auto_mem && p_rtrq && p_ready) begin
            lat_cnt  = int'($urandom_range(maxlat, 1));
            lat_addr = p_addr;
        end
        @(negedge clk);
        if (auto_mem) begin
            bus.dtr = 1'b0;
            if (lat_cnt > 0) begin
                lat_cnt--;
                if (lat_cnt == 0) begin
                    bus.dtr   = 1'b1;
                    bus.dread = memval(lat_addr);
                end
            end
        end
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        bus.flush = 1'b0;
        cycle();
        cycle();
        reset = 1'b1;
    endtask

    task automatic wait_rtrq(input string name, input int budget);
        int n = 0;
        while (!bus.rtrq && n < budget) begin
            cycle();
            n++;
        end
        chk1({name, "_rtrq_seen"}, bus.rtrq, 1'b1);
    endtask

    task automatic wait_ackd(input string name, input int budget);
        int n = 0;
        while (!bus.ackd && n < budget) begin
            cycle();
            n++;
        end
        chk1({name, "_ackd_seen"}, bus.ackd, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        reset     = 1'b0;
        bus.ready = 1'b1;
        bus.reqd  = 1'b1;
        bus.flush = 1'b0;
        bus.newpc = 32'h0;
        bus.dtr   = 1'b0;
        bus.dread = 32'h0;
        auto_mem  = 1'b1;
        maxlat    = 1;
        lat_cnt   = 0;
        n_push    = 0;
        exp_pc    = RESET_PC;

        // basic latency, plus pc wrap on the second instance
        do_reset();
        chk1("reset_rtrq", bus.rtrq, 1'b0);
        chk1("reset_ackd", bus.ackd, 1'b0);
        cycle();
        chk1("e1_rtrq", bus.rtrq, 1'b1);
        chk("e1_addr", bus.addr, 32'h0);
        chk("wrap_e1_addr", bus2.addr, 32'hFFFF_FFFC);
        cycle();
        chk1("e2_rtrq", bus.rtrq, 1'b0);
        chk1("e2_ackd", bus.ackd, 1'b0);
        cycle();
        chk1("e3_ackd", bus.ackd, 1'b1);
        chk("e3_instd", bus.instd, 32'h1234_5678);
        chk("e3_pc_d", bus.pc_d, 32'h0);
        chk1("wrap_e3_ackd", bus2.ackd, 1'b1);
        chk("wrap_e3_pc_d", bus2.pc_d, 32'hFFFF_FFFC);
        chk("wrap_e3_instd", bus2.instd, 32'h1234_5678);
        cycle();
        chk1("e4_rtrq", bus.rtrq, 1'b1);
        chk("e4_addr", bus.addr, 32'h4);
        chk1("e4_ackd", bus.ackd, 1'b0);
        cycle();
        cycle();
        chk1("wrap_e6_ackd", bus2.ackd, 1'b1);
        chk("wrap_e6_pc_d", bus2.pc_d, 32'h0);
        chk("e6_pc_d", bus.pc_d, 32'h4);

        // decode stalled: FIFO fills, issue stops
        do_reset();
        bus.reqd = 1'b0;
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (p_reset && p_rtrq && p_ready) acc++;
        end
        chk("full_accepts", acc, 32'd2);
        chk1("full_ackd", bus.ackd, 1'b1);
        chk("full_pc_d", bus.pc_d, 32'h0);
        chk("full_instd", bus.instd, 32'h1234_5678);
        chk1("full_rtrq", bus.rtrq, 1'b0);
        bus.reqd = 1'b1;
        cycle();
        chk1("drain1_ackd", bus.ackd, 1'b1);
        chk("drain1_pc_d", bus.pc_d, 32'h4);
        chk1("drain1_rtrq", bus.rtrq, 1'b0);
        cycle();
        chk1("drain2_ackd", bus.ackd, 1'b0);
        chk1("resume_rtrq", bus.rtrq, 1'b1);
        chk("resume_addr", bus.addr, 32'h8);

        // memory stall
        do_reset();
        bus.ready = 1'b0;
        cycle();
        chk1("stall_rtrq0", bus.rtrq, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk1("stall_rtrq", bus.rtrq, 1'b1);
            chk("stall_addr", bus.addr, 32'h0);
        end
        bus.ready = 1'b1;
        cycle();
        chk1("stall_release", bus.rtrq, 1'b0);
        wait_rtrq("stall_next", 10);
        chk("stall_next_addr", bus.addr, 32'h4);

        // flush while waiting for data
        auto_mem = 1'b0;
        bus.dtr  = 1'b0;
        do_reset();
        cycle();
        cycle();
        bus.flush = 1'b1;
        bus.newpc = 32'h100;
        cycle();
        bus.flush = 1'b0;
        chk1("fw_ackd", bus.ackd, 1'b0);
        chk1("fw_rtrq", bus.rtrq, 1'b0);
        cycle();
        chk1("fw_drop_rtrq", bus.rtrq, 1'b0);
        bus.dtr   = 1'b1;
        bus.dread = 32'hDEAD_BEEF;
        cycle();
        bus.dtr = 1'b0;
        chk1("fw_late_ackd", bus.ackd, 1'b0);
        chk1("fw_late_rtrq", bus.rtrq, 1'b0);
        cycle();
        chk1("fw_reissue", bus.rtrq, 1'b1);
        chk("fw_addr", bus.addr, 32'h100);
        auto_mem = 1'b1;
        wait_ackd("fw", 20);
        chk("fw_pc_d", bus.pc_d, 32'h100);
        chk("fw_instd", bus.instd, memval(32'h100));

        // flush in REQ without ready: request withdrawn
        do_reset();
        bus.ready = 1'b0;
        cycle();
        bus.flush = 1'b1;
        bus.newpc = 32'h200;
        cycle();
        bus.flush = 1'b0;
        chk1("fr_withdraw", bus.rtrq, 1'b0);
        cycle();
        chk1("fr_reissue", bus.rtrq, 1'b1);
        chk("fr_addr", bus.addr, 32'h200);
        bus.ready = 1'b1;

        // flush in REQ with ready: accepted read drained first
        auto_mem = 1'b0;
        bus.dtr  = 1'b0;
        do_reset();
        bus.ready = 1'b0;
        cycle();
        bus.ready = 1'b1;
        bus.flush = 1'b1;
        bus.newpc = 32'h200;
        cycle();
        bus.flush = 1'b0;
        chk1("fd_rtrq0", bus.rtrq, 1'b0);
        cycle();
        chk1("fd_rtrq1", bus.rtrq, 1'b0);
        cycle();
        chk1("fd_rtrq2", bus.rtrq, 1'b0);
        bus.dtr   = 1'b1;
        bus.dread = 32'hBAD0_0000;
        cycle();
        bus.dtr = 1'b0;
        chk1("fd_rtrq3", bus.rtrq, 1'b0);
        chk1("fd_ackd", bus.ackd, 1'b0);
        cycle();
        chk1("fd_reissue", bus.rtrq, 1'b1);
        chk("fd_addr", bus.addr, 32'h200);
        auto_mem = 1'b1;
        wait_ackd("fd", 20);
        chk("fd_pc_d", bus.pc_d, 32'h200);

        // reset in the middle of a read, stray dtr afterwards
        do_reset();
        bus.reqd = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        bus.reqd = 1'b1;
        cycle();
        bus.reqd = 1'b0;
        cycle();
        auto_mem = 1'b0;
        bus.dtr  = 1'b0;
        cycle();
        chk1("mr_pre_ackd", bus.ackd, 1'b1);
        chk("mr_pre_pc_d", bus.pc_d, 32'h4);
        bus.ready = 1'b0;
        reset     = 1'b0;
        cycle();
        chk1("mr_rtrq", bus.rtrq, 1'b0);
        chk1("mr_ackd", bus.ackd, 1'b0);
        chk("mr_addr", bus.addr, 32'h0);
        chk("mr_instd", bus.instd, 32'h0);
        chk("mr_pc_d", bus.pc_d, 32'h0);
        reset     = 1'b1;
        bus.dtr   = 1'b1;
        bus.dread = 32'hFEED_FACE;
        cycle();
        bus.dtr = 1'b0;
        chk1("mr_stray_ackd", bus.ackd, 1'b0);
        chk1("mr_issue", bus.rtrq, 1'b1);
        chk("mr_issue_addr", bus.addr, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk1("mr_quiet_ackd", bus.ackd, 1'b0);
        end

        // randomized traffic against the model
        auto_mem  = 1'b1;
        bus.ready = 1'b1;
        do_reset();
        n_push = 0;
        for (int i = 0; i < 4000; i++) begin
            maxlat    = int'($urandom_range(3, 1));
            bus.ready = ($urandom_range(3, 0) != 0);
            bus.reqd  = ($urandom_range(2, 0) != 0);
            bus.flush = ($urandom_range(19, 0) == 0);
            bus.newpc = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'h0000_FFFC);
            reset     = ($urandom_range(499, 0) != 0);
            cycle();
        end
        chk1("random_progress", n_push > 100, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/hs32_fetch.md
Name: hs32_fetch

Overview:
- Instruction fetch stage for the HS32 core: the producer side of the fetch→decode handshake.
- Issues 32-bit reads to the memory port at the current PC and buffers returned words in a small prefetch FIFO.
- Presents FIFO head on instd with ackd; decode consumes by asserting reqd.
- A flush from execute redirects the PC, empties the FIFO and discards any in-flight read.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- DEPTH, 2, prefetch FIFO entries; power of 2, ≥2.

Ports:
- clk  input  1  core clock (12 MHz)
- reset  input  1  reset; one clock; synchronous and active-low (0 = reset, sampled on posedge clk)
- addr  output  32  memory read address
- rtrq  output  1  memory read request
- ready  input  1  memory accepts request; address phase completes on rtrq&&ready
- dtr  input  1  read data valid
- dread  input  32  read data
- instd  output  32  instruction to decode (FIFO head)
- pc_d  output  32  address of instd
- ackd  output  1  instd/pc_d valid
- reqd  input  1  decode can accept; transfer on ackd&&reqd
- flush  input  1  redirect request
- newpc  input  32  redirect target, valid with flush

Behaviour:
- Reset (reset==0 at posedge): pc=RESET_PC; state=IDLE; FIFO count=0, pointers=0; rtrq=0, addr=0, ackd=0, instd=0, pc_d=0. Applies mid-operation; any later dtr arriving in IDLE is ignored.
- At most one outstanding read. Free-space condition: count + (state==REQ||state==WAIT) < DEPTH.
- FSM, all outputs registered:
  - IDLE: if free space and !flush → REQ; rtrq=1, addr=pc, req_pc=pc.
  - REQ: hold rtrq/addr stable until ready. On ready: pc+=4 (mod 2^32, wraps 32'hFFFF_FFFC→0), rtrq=0, → WAIT.
  - WAIT: on dtr, push {dread, req_pc}, → IDLE. dtr in IDLE/REQ is ignored.
  - DROP: on dtr, discard data → IDLE.
- FIFO: ackd = (count!=0); instd/pc_d = head entry, updated at the same posedge as count.
  - Pop on ackd&&reqd; next entry, or ackd=0, at the following posedge.
  - Push and pop in the same cycle: count unchanged. Push into an empty FIFO → ackd high at the next posedge.
  - No push when full: guaranteed by the issue rule, so overflow cannot occur.
  - instd must not change while ackd&&!reqd.
- Latency: reset released at edge 0, with ready=1 immediately and dtr one cycle after acceptance: rtrq high after edge 1, dtr sampled at edge 3, ackd high after edge 3.
- Flush (highest priority over push, pop and issue):
  - pc=newpc; FIFO cleared; ackd=0 from the next posedge; a pop in the same cycle is irrelevant.
  - State transitions on flush:
    - IDLE → IDLE.
    - REQ with ready → DROP (accepted request must be drained).
    - REQ without ready → IDLE; rtrq=0, request withdrawn. Memory samples only on rtrq&&ready.
    - WAIT without dtr → DROP.
    - WAIT with dtr → IDLE; data discarded.
    - DROP → DROP, or IDLE if dtr.
  - First fetch of newpc is issued from IDLE on the next cycle when flush is low.
  - Back-to-back flushes: the last newpc wins.
- Memory contract: stall via ready low indefinitely; dtr arrives ≥1 cycle after acceptance.

Test Plan:
- Reset, then memory ready=1 with dtr one cycle after acceptance, mem[0]=32'h1234_5678, reqd=1 → addr=0 in REQ; ackd rises after edge 3 with instd=32'h1234_5678, pc_d=0; next addr=4.
- reqd=0 held → two words buffered (pc_d 0, 4); no third rtrq while full; instd stable. Raise reqd → words delivered in order, then fetch at 8 resumes.
- ready held low 5 cycles → rtrq/addr held constant 5 cycles; no pc increment until ready.
- flush newpc=32'h100 while in WAIT → late dtr data not delivered; FIFO empty; next addr=32'h100; first delivered pc_d=32'h100.
- flush newpc=32'h200 in REQ with ready=0 → rtrq drops next cycle, then reissues with addr=32'h200. Repeat with ready=1 in the flush cycle → DROP consumes the next dtr before addr=32'h200 is issued.
- RESET_PC=32'hFFFF_FFFC, reqd=1 → pc_d sequence FFFF_FFFC, 0000_0000. Assert reset mid-WAIT → all outputs return to reset values; stray dtr ignored.
